// File: rtl/cursor_blink_seq_pkg.sv
// rtl/cursor_blink_seq_pkg.sv - shared state encoding and defaults for the cursor blink sequencer
package cursor_pkg;

  localparam int X_W_DEF     = 6;
  localparam int Y_W_DEF     = 6;
  localparam int COLOR_W_DEF = 3;
  localparam int BLACK_DEF   = 0;
  localparam int WD_CYC_DEF  = 16_000_000;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ARM_B   = 4'd1;
  localparam logic [3:0] S_WR_B    = 4'd2;
  localparam logic [3:0] S_START_B = 4'd3;
  localparam logic [3:0] S_WAIT_B  = 4'd4;
  localparam logic [3:0] S_ARM_C   = 4'd5;
  localparam logic [3:0] S_WR_C    = 4'd6;
  localparam logic [3:0] S_START_C = 4'd7;
  localparam logic [3:0] S_WAIT_C  = 4'd8;
  localparam logic [3:0] S_RESTORE = 4'd9;

  typedef enum logic [3:0] {
    IDLE    = S_IDLE,
    ARM_B   = S_ARM_B,
    WR_B    = S_WR_B,
    START_B = S_START_B,
    WAIT_B  = S_WAIT_B,
    ARM_C   = S_ARM_C,
    WR_C    = S_WR_C,
    START_C = S_START_C,
    WAIT_C  = S_WAIT_C,
    RESTORE = S_RESTORE
  } state_e;

  function automatic logic is_wait(input state_e s);
    return (s == WAIT_B) || (s == WAIT_C);
  endfunction

endpackage

// File: rtl/cursor_blink_seq_if.sv
// rtl/cursor_blink_seq_if.sv - timer handshake and framebuffer write port bundle
interface cursor_blink_seq_if
  import cursor_pkg::*;
#(
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) ();

  logic                   tmr_rst;
  logic                   tmr_init;
  logic                   tmr_done;
  logic                   wr_req;
  logic [X_W+Y_W-1:0]     wr_addr;
  logic [COLOR_W-1:0]     wr_data;
  logic                   wr_ack;

  modport master (
    output tmr_rst, tmr_init, wr_req, wr_addr, wr_data,
    input  tmr_done, wr_ack
  );

  modport slave (
    input  tmr_rst, tmr_init, wr_req, wr_addr, wr_data,
    output tmr_done, wr_ack
  );

endinterface

// File: rtl/cursor_blink_seq_fb_write_port.sv
// rtl/cursor_blink_seq_fb_write_port.sv - req/ack holding register for one framebuffer write
module fb_write_port
  import cursor_pkg::*;
#(
  parameter int AW = X_W_DEF + Y_W_DEF,
  parameter int DW = COLOR_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic          done,
  output logic          wr_req,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic          wr_ack
);

  logic          req_q, req_d;
  logic          done_q, done_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  // done is a one-cycle pulse in the cycle after the accepting edge, when wr_req is already low
  always_comb begin
    req_d  = req_q;
    done_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (req_q) begin
      if (wr_ack) begin
        req_d  = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      req_d  = 1'b1;
      addr_d = addr;
      data_d = data;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      req_q  <= req_d;
      done_q <= done_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign done    = done_q;
  assign wr_req  = req_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;

endmodule

// File: rtl/cursor_blink_seq.sv
// rtl/cursor_blink_seq.sv - blinks the cursor pixel black/saved colour using one shared interval timer
module cursor_blink_seq
  import cursor_pkg::*;
#(
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int BLACK   = BLACK_DEF,
  parameter int WD_CYC  = WD_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [X_W-1:0]      cur_x,
  input  logic [Y_W-1:0]      cur_y,
  input  logic [COLOR_W-1:0]  pix_color,
  cursor_blink_seq_if.master  bus,
  output logic                black_on,
  output logic                busy,
  output logic                err
);

  localparam int AW   = X_W + Y_W;
  localparam int WD_W = $clog2(WD_CYC + 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      sv_addr_q, sv_addr_d;
  logic [COLOR_W-1:0] sv_col_q, sv_col_d;
  logic               black_on_q, black_on_d;
  logic               err_q, err_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic [AW-1:0]      cur_addr;
  logic               moved;
  logic               wd_hit;
  logic               wp_start;
  logic               wp_done;
  logic [COLOR_W-1:0] wp_data;

  assign cur_addr = {cur_y, cur_x};
  assign moved    = (cur_addr != sv_addr_q);
  // wd_q counts the tmr_init cycle as 1, so this is the cycle the count reaches WD_CYC
  assign wd_hit   = is_wait(state_q) && (wd_q == WD_W'(WD_CYC - 1));

  always_comb begin
    state_d    = state_q;
    sv_addr_d  = sv_addr_q;
    sv_col_d   = sv_col_q;
    black_on_d = black_on_q;
    err_d      = err_q;
    wd_d       = wd_q;
    case (state_q)
      IDLE: begin
        if (enable && !err_q) begin
          sv_addr_d = cur_addr;
          sv_col_d  = pix_color;
          state_d   = ARM_B;
        end
      end
      ARM_B: state_d = enable ? WR_B : IDLE;
      WR_B: begin
        if (wp_done) begin
          black_on_d = 1'b1;
          state_d    = enable ? START_B : RESTORE;
        end
      end
      START_B: begin
        wd_d    = WD_W'(1);
        state_d = enable ? WAIT_B : RESTORE;
      end
      WAIT_B: begin
        wd_d = wd_q + WD_W'(1);
        if (wd_hit) begin
          err_d   = 1'b1;
          state_d = RESTORE;
        end else if (!enable || moved) begin
          state_d = RESTORE;
        end else if (bus.tmr_done) begin
          state_d = ARM_C;
        end
      end
      ARM_C: state_d = enable ? WR_C : RESTORE;
      WR_C: begin
        if (wp_done) begin
          black_on_d = 1'b0;
          state_d    = enable ? START_C : IDLE;
        end
      end
      START_C: begin
        wd_d    = WD_W'(1);
        state_d = enable ? WAIT_C : IDLE;
      end
      WAIT_C: begin
        wd_d = wd_q + WD_W'(1);
        if (wd_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (!enable) begin
          state_d = IDLE;
        end else if (moved || bus.tmr_done) begin
          sv_addr_d = cur_addr;
          sv_col_d  = pix_color;
          state_d   = ARM_B;
        end
      end
      RESTORE: begin
        // a move-triggered restore hands straight over to the new position's black phase
        if (wp_done) begin
          black_on_d = 1'b0;
          if (enable && !err_q) begin
            sv_addr_d = cur_addr;
            sv_col_d  = pix_color;
            state_d   = ARM_B;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sv_addr_q  <= '0;
      sv_col_q   <= '0;
      black_on_q <= 1'b0;
      err_q      <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      sv_addr_q  <= sv_addr_d;
      sv_col_q   <= sv_col_d;
      black_on_q <= black_on_d;
      err_q      <= err_d;
      wd_q       <= wd_d;
    end
  end

  // a write is launched on the edge that enters a write state, so wr_req is up for its first cycle
  assign wp_start = (state_d != state_q) &&
                    ((state_d == WR_B) || (state_d == WR_C) || (state_d == RESTORE));
  assign wp_data  = (state_d == WR_B) ? COLOR_W'(BLACK) : sv_col_q;

  fb_write_port #(
    .AW (AW),
    .DW (COLOR_W)
  ) u_fb_write_port (
    .clk     (clk),
    .rst     (rst),
    .start   (wp_start),
    .addr    (sv_addr_q),
    .data    (wp_data),
    .done    (wp_done),
    .wr_req  (bus.wr_req),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .wr_ack  (bus.wr_ack)
  );

  assign bus.tmr_rst  = (state_q == ARM_B) || (state_q == ARM_C);
  assign bus.tmr_init = (state_q == START_B) || (state_q == START_C);
  assign black_on     = black_on_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;

endmodule
